// File: rtl/jk_seq_driver.sv
// jk_seq_driver
// Command stage for a JK flip-flop. Plays a four-step {j,k} program, holding
// each step for DWELL clocks, after a one-cycle INIT that forces the flop to 0.
// A reference JK model tracks what the flop should hold. The flop output fed
// back on q_in is compared against it, and failures are logged in a sticky
// flag and a saturating counter.
module jk_seq_driver #(
  parameter logic [7:0] PROGRAM = 8'b10_01_00_11, // step0 = [7:6] ... step3 = [1:0]
  parameter int         DWELL   = 2,              // clocks per step, 1..255
  parameter bit         LOOP    = 1'b0            // 1: DONE goes straight back to INIT
) (
  input  logic       clk,
  input  logic       rst,        // synchronous, active-low
  input  logic       start,
  input  logic       q_in,
  output logic       j,
  output logic       k,
  output logic       busy,
  output logic       done,
  output logic [1:0] step_idx,
  output logic       mismatch,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Last dwell count of a step; the counter wraps to 0 after this value.
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_reg, state_next;
  logic [7:0] dwell_reg, dwell_next;
  logic [1:0] step_next;
  logic       j_next, k_next, busy_next, done_next;
  logic       clear_stats;
  logic       exp_reg, exp_next;
  logic       chk_en_reg;

  // Selects the {j,k} pair for a program step.
  function automatic logic [1:0] prog_pair(input logic [1:0] s);
    logic [1:0] pair;
    case (s)
      2'd0:    pair = PROGRAM[7:6];
      2'd1:    pair = PROGRAM[5:4];
      2'd2:    pair = PROGRAM[3:2];
      default: pair = PROGRAM[1:0];
    endcase
    return pair;
  endfunction

  // Next-state, step/dwell sequencing and next values of the registered outputs.
  always_comb begin
    state_next  = state_reg;
    dwell_next  = dwell_reg;
    step_next   = step_idx;
    clear_stats = 1'b0;
    j_next      = 1'b0;
    k_next      = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = INIT;
          step_next   = 2'd0;
          dwell_next  = 8'd0;
          clear_stats = 1'b1;
        end
      end
      INIT: begin
        state_next = RUN;
        step_next  = 2'd0;
        dwell_next = 8'd0;
      end
      RUN: begin
        if (dwell_reg == DWELL_LAST) begin
          dwell_next = 8'd0;
          step_next  = step_idx + 2'd1;   // wraps to 0 after the last step
          if (step_idx == 2'd3) begin
            state_next = DONE;
          end
        end else begin
          dwell_next = dwell_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = LOOP ? INIT : IDLE;
        step_next  = 2'd0;
        dwell_next = 8'd0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_next)
      INIT: begin
        j_next = 1'b0;
        k_next = 1'b1;
      end
      RUN: begin
        {j_next, k_next} = prog_pair(step_next);
      end
      default: begin
        j_next = 1'b0;
        k_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  // State register and registered flop drives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      dwell_reg <= 8'd0;
      step_idx  <= 2'd0;
      j         <= 1'b0;
      k         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      dwell_reg <= dwell_next;
      step_idx  <= step_next;
      j         <= j_next;
      k         <= k_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Reference JK behaviour applied to the same registered j,k the flop sees.
  always_comb begin
    exp_next = exp_reg;
    case ({j, k})
      2'b00:   exp_next = exp_reg;
      2'b01:   exp_next = 1'b0;
      2'b10:   exp_next = 1'b1;
      default: exp_next = ~exp_reg;
    endcase
  end

  // Reference model, check window and error bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_reg    <= 1'b0;
      chk_en_reg <= 1'b0;
      mismatch   <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      exp_reg    <= exp_next;
      // Delayed by one so the DONE cycle still checks the last RUN step's effect.
      chk_en_reg <= (state_reg == INIT) || (state_reg == RUN);
      if (clear_stats) begin
        mismatch  <= 1'b0;
        err_count <= 8'd0;
      end else if (chk_en_reg && (q_in != exp_reg)) begin
        mismatch <= 1'b1;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule
